// File: rtl/sfp_accum_dump_if.sv
// Sample-in / block-sum-out handshake bundle for the sfp integrate-and-dump accumulator.
// The master side is the producer/consumer pair around the block; the slave side is the accumulator.
interface sfp_accum_dump_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
);
  logic signed [IN_W-1:0]  in_val;
  logic                    in_valid;
  logic                    in_ready;
  logic                    clear;
  logic signed [OUT_W-1:0] out_val;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_val, in_valid, clear, out_ready,
    input  in_ready, out_val, out_valid
  );

  modport slave (
    input  in_val, in_valid, clear, out_ready,
    output in_ready, out_val, out_valid
  );
endinterface

// File: rtl/sfp_accum_dump.sv
// Integrate-and-dump accumulator: sums exactly N accepted signed fixed-point samples at full
// precision and hands each block sum out through a registered valid/ready output.
module sfp_accum_dump #(
  parameter int N      = 16,
  parameter int IN_IW  = 2,
  parameter int IN_QW  = 6,
  parameter int OUT_IW = 6,
  parameter int OUT_QW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  sfp_accum_dump_if.slave    bus
);
  localparam int W_IN  = IN_IW + IN_QW;
  localparam int W_OUT = OUT_IW + OUT_QW;
  localparam int CNT_W = (N < 2) ? 1 : $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("sfp_accum_dump: N must be at least 2");
  end
  if (OUT_IW != IN_IW + $clog2(N) || OUT_QW != IN_QW) begin : g_bad_w
    $error("Incorrect output word length for accumulate");
  end

  // Binary points already line up (equal fractional widths), so only the integer part grows.
  function automatic logic signed [W_OUT-1:0] sign_ext(input logic signed [W_IN-1:0] x);
    return {{(W_OUT - W_IN){x[W_IN-1]}}, x};
  endfunction

  logic signed [W_OUT-1:0] acc_p0;
  logic signed [W_OUT-1:0] in_ext_p0;
  logic signed [W_OUT-1:0] sum_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [W_OUT-1:0] out_val_p1;
  logic                    vld_p1;
  logic                    last_p0;
  logic                    accept_p0;
  logic                    dump_p0;
  logic                    consume_p1;

  assign in_ext_p0  = sign_ext(bus.in_val);
  assign sum_p0     = acc_p0 + in_ext_p0;
  assign last_p0    = (cnt_p0 == CNT_LAST);
  // Only the block-closing sample stalls behind an unconsumed sum; earlier samples keep flowing.
  assign bus.in_ready = !bus.clear && !(last_p0 && vld_p1 && !bus.out_ready);
  assign accept_p0  = bus.in_valid && bus.in_ready;
  assign dump_p0    = accept_p0 && last_p0;
  assign consume_p1 = vld_p1 && bus.out_ready;

  // ---- stage p0: running sum and sample count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (bus.clear || dump_p0) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept_p0) begin
      acc_p0 <= sum_p0;
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // ---- stage p1: held block sum; a dump coinciding with a consume reloads without a bubble ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (dump_p0) begin
      out_val_p1 <= sum_p0;
      vld_p1     <= 1'b1;
    end else if (consume_p1) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.out_val   = out_val_p1;
  assign bus.out_valid = vld_p1;
endmodule

// File: doc/sfp_accum_dump.md
# sfp_accum_dump

Integrate-and-dump accumulator for signed fixed-point (sfp) samples. It sums exactly N accepted input samples at full precision and presents each block sum on a registered output with a valid/ready handshake. It sits directly downstream of `sfp_mult_full` and consumes its product stream to form multiply-accumulate and correlator datapaths. Word growth is exact, so no clipping or rounding occurs inside the block.

## Interface
- `N`, default 16: samples per dump; must be ≥ 2. If N < 2, elaboration raises `$error`.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in`  sfp.in  in.iw+in.qw: input sample.
- `in_valid`  in  1: `in` carries a sample this cycle.
- `in_ready`  out  1: block can accept a sample this cycle; combinational.
- `clear`  in  1: synchronous abort of the current block.
- `out`  sfp.out  out.iw+out.qw: block sum, registered.
- `out_valid`  out  1: `out` holds an unconsumed sum.
- `out_ready`  in  1: downstream consumes `out` this cycle.
- Width rule, checked at elaboration:
  - `fp_iw(out)` == `fp_iw(in)` + $clog2(N).
  - `fp_qw(out)` == `fp_qw(in)`.
  - Any mismatch raises `$error`: "Incorrect output word length for accumulate".

## Operation
- Accept: a sample is accepted when `in_valid && in_ready`.
- Internal state:
  - accumulator `acc`, W_out bits wide, where W_out = out.iw + out.qw;
  - counter `cnt`, 0..N-1;
  - output register `out.val` plus `out_valid`.
- Input alignment: `in.val` is sign-extended to W_out with the binary point aligned, so there is no fractional shift.
- Accept with `cnt` < N-1: `acc <= acc + in_ext` and `cnt <= cnt + 1`.
- Accept with `cnt` == N-1 (dump):
  - `out.val <= acc + in_ext`;
  - `out_valid <= 1`;
  - `acc <= 0` and `cnt <= 0`.
- Consume: `out_valid && out_ready` with no dump in the same cycle clears `out_valid` to 0.
- Consume and dump in the same cycle: the new sum is loaded and `out_valid` stays 1. No bubble occurs.
- Backpressure: `in_ready` = !clear && !(cnt == N-1 && out_valid && !out_ready).
  - Non-final samples are always accepted while a result is pending.
  - Only the sample that would overwrite an unconsumed sum stalls.
- Clear:
  - `clear` = 1 sets `acc <= 0` and `cnt <= 0`, and forces `in_ready` = 0, so no sample is accepted that cycle.
  - A pending `out`/`out_valid` is unaffected and is still consumed normally.
- Overflow: cannot occur. The sum of N samples fits W_out by construction, including N × most-negative value.
- `in_valid` low: the cycle is ignored and the state is held. Invalid cycles do not count toward N.

## Timing
- Reset (async assert): `acc`=0, `cnt`=0, `out.val`=0, `out_valid`=0.
  - `in_ready` follows its equation, so it is 1 out of reset when `clear`=0.
  - Reset mid-block discards the partial sum and any pending output.
- Latency: `out_valid` rises on the clock edge that accepts the Nth sample, and is visible the cycle after.
- Throughput: 1 sample/clk sustained when `out_ready` = 1 or the output is consumed within N-1 cycles of the dump.
- `out.val` is stable while `out_valid` && !`out_ready`. AXI-style rule: valid never drops without a consume.
- `in_ready` has a combinational path from `out_ready` and `clear`. There is no path from `in_valid`.

## Test plan
- Basic dump. Setup: N=4, in iw=2 qw=6, out iw=4 qw=6. Stimulus: inputs 1.0, 0.5, -0.25, 0.75 on consecutive cycles, `out_ready`=1. Required: `out` = 2.0 (val 128), `out_valid` high for exactly 1 cycle, the cycle after the 4th accept.
- Extreme values. Stimulus: 4 × -2.0 gives out -8.0 (val -512); 4 × 1.984375 gives 7.9375 (val 508). Required: no wrap in either case.
- Backpressure. Setup: `out_ready`=0 after the first dump, then samples streamed continuously. Required:
  - 3 more samples are accepted;
  - `in_ready`=0 on the 4th;
  - first sum is held unchanged;
  - raising `out_ready` lets the 4th sample be accepted that same cycle, and the second sum is loaded with no bubble.
- Gapped input. Stimulus: `in_valid` toggles 1,0,1,0…. Required: dump only after 4 valid samples, with the sum equal to the valid samples only.
- Clear mid-block. Stimulus: 2 samples (1.0, 1.0), then `clear` together with `in_valid`, then 4 × 0.5. Required: `in_ready`=0 during the clear cycle, then dump = 2.0 (the earlier 2.0 partial sum is discarded).
- Async reset mid-block. Stimulus: assert `rst_n`=0 between clock edges after 2 samples with a result pending. Required: `out_valid` and `out.val` go to 0 immediately, and the next 4 samples produce a correct fresh sum.
